wb_queue32: RTL and testbench
=============================

# wb_queue32

Write-back buffer between the execute stage (mov32/ALU results) and the register-file write port. Accepts 32-bit results tagged with a destination register, holds them in order in a small FIFO, drains them to the register file one per cycle under a ready handshake, and provides a combinational forwarding lookup so readers see pending, not-yet-written values.

## Interface
- `DEPTH`, 4: number of queue entries; power of two, 2..16.
- `RA_W`, 5: register address width.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `in_valid`  in  1  producer has a result.
- `in_ready`  out  1  queue can accept; equals `!full`.
- `in_rd`  in  RA_W  destination register.
- `in_data`  in  32  result value.
- `wr_en`  out  1  head entry valid toward the register file.
- `wr_ready`  in  1  register file accepts this cycle.
- `wr_addr`  out  RA_W  head destination.
- `wr_data`  out  32  head value.
- `rs_addr`  in  RA_W  forwarding lookup address.
- `fwd_hit`  out  1  a queued entry targets `rs_addr`.
- `fwd_data`  out  32  value of the youngest matching entry.
- `count`  out  $clog2(DEPTH)+1  occupancy.

## Operation
- Push when `in_valid && in_ready`; pop when `wr_en && wr_ready`. Both may occur in the same cycle.
- `in_rd == 0`: handshake completes, nothing is stored (register 0 is hardwired).
- `in_ready` depends only on registered occupancy: full blocks a push even when a pop occurs in the same cycle.
- Empty: `wr_en = 0`; `wr_addr`/`wr_data` are don't-care but driven 0.
- Storage: circular buffer with head/tail pointers of `$clog2(DEPTH)` bits, wrapping modulo DEPTH, plus count; full = (count == DEPTH).
- Forwarding: compares `rs_addr` against all valid entries; youngest (closest to tail) wins. `rs_addr == 0` never hits. The incoming `in_*` is not searched (no input bypass). `fwd_data = 0` when no hit.
- Data is transferred bit-exact; no transformation.

## Timing
- Reset: count = 0, pointers = 0, entry valid bits cleared; `wr_en = 0`, `fwd_hit = 0`, `fwd_data = 0`, `wr_addr = 0`, `wr_data = 0`, `in_ready = 1`.
- Reset asserted mid-operation discards all queued entries immediately, with no register-file write.
- Latency: a value pushed at edge N appears on `wr_*` with `wr_en = 1` after edge N when the queue was empty; minimum 1 cycle, no same-cycle pass-through.
- Forwarding visibility: a value pushed at edge N is visible to `fwd_*` after edge N and disappears after the edge where it is popped.
- `wr_*` remain stable while `wr_en && !wr_ready`.
- Simultaneous push and pop when not full: count unchanged, both pointers advance.
- Outputs `wr_*`, `fwd_*`, `in_ready`, and `count` are combinational from registered state and `rs_addr` only; there is no comb path from `in_valid` or `wr_ready`.

## Structure
- Package `wb_pkg`: `RA_W` default, typedef `wb_entry_t` {valid, rd[RA_W], data[32]}, constant `REG_ZERO = 0`.
- Sub-module `wb_fwd_match`: parameterised priority match over the entry array, ordered by age from head; returns hit and data.
- Top level holds the pointers, count, entry array and handshake logic.

## Test plan
- Reset then single push (rd=3, 0xDEADBEEF) with `wr_ready = 1` -> next cycle `wr_en = 1`, `wr_addr = 3`, `wr_data = 0xDEADBEEF`; following cycle count = 0.
- `wr_ready = 0`, push 5 values -> first 4 are accepted, `in_ready = 0` on the 5th, count = 4; raise `wr_ready` -> values drain in FIFO order, one per cycle.
- Fill to full, then push and pop in the same cycle -> push is refused, pop occurs, count = 3. At count 2, simultaneous push and pop -> count stays 2; drive 20 operations so the pointers wrap.
- Queue holds rd=7 (0x1) and then rd=7 (0x2); `rs_addr = 7` -> `fwd_hit = 1`, `fwd_data = 0x2`; after both pop -> `fwd_hit = 0`, `fwd_data = 0`.
- Push with rd=0 -> `in_ready` handshake completes, count unchanged, `wr_en` stays 0; `rs_addr = 0` -> `fwd_hit = 0`.
- With 3 entries queued, assert `rst_n = 0` asynchronously between edges -> `wr_en`, `count`, and `fwd_hit` go to 0 immediately, and no write occurs after release.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared constants and types for the write-back queue.
package wb_pkg;

    localparam int RA_W_DEFAULT = 5;
    localparam int DATA_W       = 32;
    localparam int REG_ZERO     = 0;

    typedef struct packed {
        logic                    valid;
        logic [RA_W_DEFAULT-1:0] rd;
        logic [DATA_W-1:0]       data;
    } wb_entry_t;

endpackage

// File: rtl/wb_fwd_match.sv
// Priority match of a read address against the queued entries; the youngest
// matching entry (closest to the tail) supplies the forwarded value.
module wb_fwd_match
    import wb_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int RA_W  = RA_W_DEFAULT
) (
    input  logic [DEPTH-1:0]         valid_i,
    input  logic [RA_W-1:0]          rd_i   [DEPTH],
    input  logic [DATA_W-1:0]        data_i [DEPTH],
    input  logic [$clog2(DEPTH)-1:0] head_i,
    input  logic [RA_W-1:0]          rs_addr_i,
    output logic                     hit_o,
    output logic [DATA_W-1:0]        data_o
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [PTR_W-1:0] idx;

    // Walk oldest to youngest so a later match overrides an earlier one.
    always_comb begin
        hit_o  = 1'b0;
        data_o = '0;
        idx    = '0;
        if (rs_addr_i != RA_W'(REG_ZERO)) begin
            for (int i = 0; i < DEPTH; i++) begin
                idx = head_i + PTR_W'(i);
                if (valid_i[idx] && (rd_i[idx] == rs_addr_i)) begin
                    hit_o  = 1'b1;
                    data_o = data_i[idx];
                end
            end
        end
    end

endmodule

// File: rtl/wb_queue32.sv
// In-order write-back buffer between execute and the register-file write port,
// with a combinational forwarding lookup over the pending entries.
module wb_queue32
    import wb_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int RA_W  = RA_W_DEFAULT
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [RA_W-1:0]          in_rd,
    input  logic [31:0]              in_data,
    output logic                     wr_en,
    input  logic                     wr_ready,
    output logic [RA_W-1:0]          wr_addr,
    output logic [31:0]              wr_data,
    input  logic [RA_W-1:0]          rs_addr,
    output logic                     fwd_hit,
    output logic [31:0]              fwd_data,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PTR_W-1:0]  head_q, head_d;
    logic [PTR_W-1:0]  tail_q, tail_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [DEPTH-1:0]  valid_q;
    logic [RA_W-1:0]   rd_q   [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];

    logic full;
    logic push;
    logic store;
    logic pop;

    // Handshake: a transfer happens on a rising edge where valid and ready are
    // both high; ready never depends on the partner's valid in the same cycle.
    assign full     = (count_q == CNT_W'(DEPTH));
    assign in_ready = !full;
    assign push     = in_valid && in_ready;
    assign store    = push && (in_rd != RA_W'(REG_ZERO));
    assign wr_en    = (count_q != '0);
    assign pop      = wr_en && wr_ready;

    assign wr_addr  = wr_en ? rd_q[head_q]   : '0;
    assign wr_data  = wr_en ? data_q[head_q] : '0;
    assign count    = count_q;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q + CNT_W'(store) - CNT_W'(pop);
        if (store) tail_d = tail_q + PTR_W'(1);
        if (pop)   head_d = head_q + PTR_W'(1);
    end

    // Store and pop never touch the same slot: head == tail only when empty
    // (no pop) or full (no push).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            valid_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                rd_q[i]   <= '0;
                data_q[i] <= '0;
            end
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            if (store) begin
                valid_q[tail_q] <= 1'b1;
                rd_q[tail_q]    <= in_rd;
                data_q[tail_q]  <= in_data;
            end
            if (pop) valid_q[head_q] <= 1'b0;
        end
    end

    wb_fwd_match #(
        .DEPTH (DEPTH),
        .RA_W  (RA_W)
    ) u_fwd (
        .valid_i   (valid_q),
        .rd_i      (rd_q),
        .data_i    (data_q),
        .head_i    (head_q),
        .rs_addr_i (rs_addr),
        .hit_o     (fwd_hit),
        .data_o    (fwd_data)
    );

endmodule

// File: tb/tb_wb_queue32.sv
// Randomised and directed bench for wb_queue32 against a queue-based model.
module tb_wb_queue32;

    localparam int DEPTH = 4;
    localparam int RA_W  = 5;

    typedef struct packed {
        logic [RA_W-1:0] rd;
        logic [31:0]     data;
    } ent_t;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [RA_W-1:0]   in_rd = '0;
    logic [31:0]       in_data = '0;
    logic              wr_en;
    logic              wr_ready = 1'b0;
    logic [RA_W-1:0]   wr_addr;
    logic [31:0]       wr_data;
    logic [RA_W-1:0]   rs_addr = '0;
    logic              fwd_hit;
    logic [31:0]       fwd_data;
    logic [2:0]        count;

    int n_checks = 0;
    int n_errors = 0;

    ent_t                 mq[$];
    logic [RA_W+31:0]     exp_q[$];

    wb_queue32 #(.DEPTH(DEPTH), .RA_W(RA_W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_rd    (in_rd),
        .in_data  (in_data),
        .wr_en    (wr_en),
        .wr_ready (wr_ready),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .rs_addr  (rs_addr),
        .fwd_hit  (fwd_hit),
        .fwd_data (fwd_data),
        .count    (count)
    );

    // Clock / reset
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_fwd(input logic [RA_W-1:0] rs, output logic hit,
                                      output logic [31:0] d);
        hit = 1'b0;
        d   = '0;
        if (rs != '0) begin
            for (int i = mq.size() - 1; i >= 0; i--) begin
                if (mq[i].rd == rs) begin
                    hit = 1'b1;
                    d   = mq[i].data;
                    break;
                end
            end
        end
    endfunction

    // Reference model: queue contents follow the accept/drain rules directly.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq.delete();
            exp_q.delete();
        end else begin
            logic do_pop;
            logic acc;
            do_pop = (mq.size() != 0) && wr_ready;
            acc    = in_valid && (mq.size() < DEPTH);
            if (do_pop) void'(mq.pop_front());
            if (acc && in_rd != '0) begin
                mq.push_back('{rd: in_rd, data: in_data});
                exp_q.push_back({in_rd, in_data});
            end
        end
    end

    // Monitor / scoreboard, sampled away from the active edge.
    always @(negedge clk) begin
        logic             h;
        logic [31:0]      d;
        logic [RA_W+31:0] e;
        chk("count", 32'(count), 32'(mq.size()));
        chk("in_ready", 32'(in_ready), 32'(mq.size() < DEPTH));
        chk("wr_en", 32'(wr_en), 32'(mq.size() != 0));
        model_fwd(rs_addr, h, d);
        chk("fwd_hit", 32'(fwd_hit), 32'(h));
        chk("fwd_data", fwd_data, d);
        if (wr_en && wr_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_write: addr %h data %h with nothing expected", wr_addr, wr_data);
            end else begin
                e = exp_q.pop_front();
                chk("wr_addr", 32'(wr_addr), 32'(e[RA_W+31:32]));
                chk("wr_data", wr_data, e[31:0]);
            end
        end else if (!wr_en) begin
            chk("wr_addr_idle", 32'(wr_addr), 32'd0);
            chk("wr_data_idle", wr_data, 32'd0);
        end
    end

    // Driver: apply one cycle of inputs, return just after the edge.
    task automatic drive(input logic v, input logic [RA_W-1:0] rd, input logic [31:0] data,
                         input logic wrr, input logic [RA_W-1:0] rs);
        in_valid = v;
        in_rd    = rd;
        in_data  = data;
        wr_ready = wrr;
        rs_addr  = rs;
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while (mq.size() != 0 && n < budget) begin
            drive(1'b0, '0, '0, 1'b1, rs_addr);
            n++;
        end
        n_checks++;
        if (mq.size() != 0) begin
            n_errors++;
            $display("FAIL drain_timeout: %0d entries left, 0 required", mq.size());
        end
    endtask

    initial begin
        #2;
        chk("rst_wr_en", 32'(wr_en), 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_fwd_hit", 32'(fwd_hit), 32'd0);
        chk("rst_fwd_data", fwd_data, 32'd0);
        chk("rst_wr_addr", 32'(wr_addr), 32'd0);
        chk("rst_wr_data", wr_data, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Single push, one-cycle latency to the write port.
        drive(1'b1, 5'd3, 32'hDEADBEEF, 1'b1, 5'd3);
        drive(1'b0, '0, '0, 1'b1, 5'd3);
        drive(1'b0, '0, '0, 1'b1, 5'd3);

        // Five pushes into a stalled queue; the fifth is refused.
        for (int i = 0; i < 5; i++) drive(1'b1, RA_W'(i + 1), 32'h1000 + 32'(i), 1'b0, 5'd2);
        chk("full_count", 32'(count), 32'd4);
        chk("full_in_ready", 32'(in_ready), 32'd0);
        // Push+pop while full: push refused, pop happens.
        drive(1'b1, 5'd9, 32'hBAD0BAD0, 1'b1, 5'd9);
        chk("full_pushpop_count", 32'(count), 32'd3);
        drive(1'b0, '0, '0, 1'b1, 5'd4);
        chk("count_two", 32'(count), 32'd2);
        // Steady push+pop at count 2, enough to wrap the pointers.
        for (int i = 0; i < 20; i++)
            drive(1'b1, RA_W'($urandom_range(1, 7)), $urandom, 1'b1, RA_W'($urandom_range(0, 7)));
        chk("steady_count", 32'(count), 32'd2);
        drain(20);

        // Youngest match wins.
        drive(1'b1, 5'd7, 32'h1, 1'b0, 5'd7);
        drive(1'b1, 5'd7, 32'h2, 1'b0, 5'd7);
        chk("fwd_young_hit", 32'(fwd_hit), 32'd1);
        chk("fwd_young_data", fwd_data, 32'h2);
        drain(10);
        chk("fwd_gone_hit", 32'(fwd_hit), 32'd0);
        chk("fwd_gone_data", fwd_data, 32'd0);

        // rd = 0 is accepted but not stored; rs = 0 never hits.
        drive(1'b1, 5'd0, 32'hFFFF0000, 1'b0, 5'd0);
        chk("rd0_count", 32'(count), 32'd0);
        drive(1'b1, 5'd4, 32'h44, 1'b0, 5'd0);
        drive(1'b1, 5'd0, 32'h55, 1'b0, 5'd0);
        chk("rd0_count_after", 32'(count), 32'd1);
        chk("rs0_hit", 32'(fwd_hit), 32'd0);
        drain(10);

        // Randomised traffic.
        for (int i = 0; i < 400; i++)
            drive(1'($urandom_range(0, 3) != 0), RA_W'($urandom_range(0, 7)), $urandom,
                  1'($urandom_range(0, 2) != 0), RA_W'($urandom_range(0, 7)));
        drain(20);

        // Asynchronous reset with three entries pending.
        for (int i = 0; i < 3; i++) drive(1'b1, RA_W'(i + 10), 32'hC0DE0000 + 32'(i), 1'b0, 5'd11);
        chk("pre_rst_count", 32'(count), 32'd3);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_wr_en", 32'(wr_en), 32'd0);
        chk("async_rst_count", 32'(count), 32'd0);
        chk("async_rst_fwd_hit", 32'(fwd_hit), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) drive(1'b0, '0, '0, 1'b1, 5'd11);
        chk("post_rst_wr_en", 32'(wr_en), 32'd0);

        n_checks++;
        if (exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL scoreboard_leftover: %0d writes missing, 0 required", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
